mips32r2_scan_tlb: RTL and testbench

- Successor to the slow rotating-scan TLB. Entries live in one group-wide async RAM, and a scan pointer steps through the groups one per cycle.
- Adds per-port probe request/response handshakes, so every probe terminates: a hit, or a definitive miss after one full sweep.
- Adds explicit read/write handshakes, a write-hold of the scan pointer, and per-port kill.
- Serves IF/MEM translation and the TLBP/TLBR/TLBWI/TLBWR paths of the CP0 unit.

---
 rtl/mips32r2_scan_tlb_pkg.sv | 51 +++++
 rtl/async_ram.sv | 23 ++
 rtl/mips32r2_tlb_probe_port.sv | 114 +++++++++++
 rtl/mips32r2_scan_tlb.sv | 100 ++++++++++
 tb/tb_mips32r2_scan_tlb.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32r2_scan_tlb_pkg.sv
// Shared types for the rotating-scan TLB: entry layout, page sizes,
// match helpers and the probe-port state encoding.
package mips32r2_scan_tlb_pkg;

   typedef enum logic [1:0] {
      PS4K  = 2'd0,
      PS16K = 2'd1,
      PS64K = 2'd2
   } page_size_e;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      page_size_e  ps;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      PROBE_IDLE = 2'd0,
      PROBE_SCAN = 2'd1,
      PROBE_RESP = 2'd2
   } probe_state_e;

   function automatic logic [18:0] vpn2_mask(page_size_e ps);
      logic [18:0] m;
      unique case (1'b1)
         (ps == PS16K): m = 19'h7fffc;
         (ps == PS64K): m = 19'h7fff0;
         default:       m = 19'h7ffff;
      endcase
      return m;
   endfunction

   function automatic logic tlb_match(
      tlb_entry_t  e,
      logic [18:0] vpn2,
      logic [7:0]  asid
   );
      return (((vpn2 ^ e.vpn2) & vpn2_mask(e.ps)) == 19'h0)
          && (e.g || (e.asid == asid));
   endfunction

endpackage

// File: rtl/async_ram.sv
// Storage array with synchronous write and combinational read.
// Contents are deliberately left uninitialised by reset.
module async_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mips32r2_tlb_probe_port.sv
// One probe channel: latches a request, compares it against each group
// as the scan pointer passes, and reports a hit or a sweep-complete miss.
module mips32r2_tlb_probe_port
   import mips32r2_scan_tlb_pkg::*;
#(
   parameter int GROUP_SIZE = 4,
   parameter int GROUPS     = 16
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    req_valid,
   output logic                                    req_ready,
   input  logic [18:0]                             vpn2,
   input  logic [7:0]                              asid,
   input  logic                                    kill,
   input  tlb_entry_t [GROUP_SIZE-1:0]             group,
   input  logic [$clog2(GROUPS)-1:0]               sp,
   input  logic                                    commit,
   output logic                                    resp_valid,
   output logic                                    resp_hit,
   output logic [$clog2(GROUPS*GROUP_SIZE)-1:0]    resp_index,
   output tlb_entry_t                              resp_entry
);

   localparam int OW = $clog2(GROUP_SIZE);
   localparam int GW = $clog2(GROUPS);

   probe_state_e state_q, state_d;
   logic [18:0]  vpn2_q;
   logic [7:0]   asid_q;
   logic [GW-1:0] cnt_q, cnt_d;
   logic         hit_any;
   logic [OW-1:0] hit_slot;
   logic         accept;
   logic         set_hit;
   logic         set_miss;

   // Ascending scan so the highest matching slot is the one kept.
   always_comb begin
      hit_any  = 1'b0;
      hit_slot = '0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
         if (tlb_match(group[i], vpn2_q, asid_q)) begin
            hit_any  = 1'b1;
            hit_slot = i[OW-1:0];
         end
      end
   end

   assign accept = (state_q == PROBE_IDLE) && req_valid;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      set_hit  = 1'b0;
      set_miss = 1'b0;
      unique case (state_q)
         PROBE_IDLE: begin
            if (req_valid) state_d = PROBE_SCAN;
         end
         PROBE_SCAN: begin
            if (kill) begin
               state_d = PROBE_IDLE;
            end else if (!commit) begin
               if (hit_any) begin
                  state_d = PROBE_RESP;
                  set_hit = 1'b1;
               end else if (cnt_q == GW'(GROUPS - 1)) begin
                  state_d  = PROBE_RESP;
                  set_miss = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PROBE_RESP: state_d = PROBE_IDLE;
         default:    state_d = PROBE_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= PROBE_IDLE;
         vpn2_q     <= '0;
         asid_q     <= '0;
         cnt_q      <= '0;
         resp_hit   <= 1'b0;
         resp_index <= '0;
         resp_entry <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            vpn2_q <= vpn2;
            asid_q <= asid;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
         if (set_hit) begin
            resp_hit   <= 1'b1;
            resp_index <= {sp, hit_slot};
            resp_entry <= group[hit_slot];
         end else if (set_miss) begin
            resp_hit   <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
         end
      end
   end

   assign req_ready  = (state_q == PROBE_IDLE);
   assign resp_valid = (state_q == PROBE_RESP) && !kill;

endmodule

// File: rtl/mips32r2_scan_tlb.sv
// Rotating-scan TLB: one group per cycle is presented to the read,
// write and probe paths; the scan pointer holds on a write commit.
module mips32r2_scan_tlb
   import mips32r2_scan_tlb_pkg::*;
#(
   parameter int ENTRIES         = 64,
   parameter int GROUP_SIZE      = 4,
   parameter int NUM_PROBE_PORTS = 2
) (
   input  logic                                              clock,
   input  logic                                              reset,
   input  logic                                              r_valid,
   input  logic [$clog2(ENTRIES)-1:0]                        r_index,
   output logic                                              r_ready,
   output tlb_entry_t                                        r_resp,
   input  logic                                              w_valid,
   input  logic [$clog2(ENTRIES)-1:0]                        w_index,
   input  tlb_entry_t                                        w_data,
   output logic                                              w_ready,
   input  logic [NUM_PROBE_PORTS-1:0]                        p_req_valid,
   output logic [NUM_PROBE_PORTS-1:0]                        p_req_ready,
   input  logic [NUM_PROBE_PORTS-1:0][18:0]                  p_vpn2,
   input  logic [NUM_PROBE_PORTS-1:0][7:0]                   p_asid,
   input  logic [NUM_PROBE_PORTS-1:0]                        p_kill,
   output logic [NUM_PROBE_PORTS-1:0]                        p_resp_valid,
   output logic [NUM_PROBE_PORTS-1:0]                        p_resp_hit,
   output logic [NUM_PROBE_PORTS-1:0][$clog2(ENTRIES)-1:0]   p_resp_index,
   output tlb_entry_t [NUM_PROBE_PORTS-1:0]                  p_resp_entry
);

   localparam int GROUPS = ENTRIES / GROUP_SIZE;
   localparam int IW     = $clog2(ENTRIES);
   localparam int OW     = $clog2(GROUP_SIZE);
   localparam int GW     = $clog2(GROUPS);
   localparam int EW     = $bits(tlb_entry_t);

   logic [GW-1:0]                  sp;
   logic                           commit;
   logic [GROUP_SIZE*EW-1:0]       ram_rdata;
   tlb_entry_t [GROUP_SIZE-1:0]    group_rd;
   tlb_entry_t [GROUP_SIZE-1:0]    group_wr;

   // A write pending across reset is dropped, not committed.
   assign commit  = !reset && w_valid && (w_index[IW-1:OW] == sp);
   assign w_ready = commit;

   always_ff @(posedge clock) begin
      if (reset) begin
         sp <= '0;
      end else if (!commit) begin
         sp <= sp + 1'b1;
      end
   end

   async_ram #(
      .DEPTH (GROUPS),
      .WIDTH (GROUP_SIZE * EW)
   ) u_ram (
      .clock (clock),
      .we    (commit),
      .waddr (sp),
      .wdata (group_wr),
      .raddr (sp),
      .rdata (ram_rdata)
   );

   assign group_rd = ram_rdata;

   always_comb begin
      group_wr                    = group_rd;
      group_wr[w_index[OW-1:0]]   = w_data;
   end

   assign r_ready = !reset && r_valid
                 && (r_index[IW-1:OW] == sp) && !commit;
   assign r_resp  = r_ready ? group_rd[r_index[OW-1:0]] : '0;

   for (genvar i = 0; i < NUM_PROBE_PORTS; i++) begin : g_port
      mips32r2_tlb_probe_port #(
         .GROUP_SIZE (GROUP_SIZE),
         .GROUPS     (GROUPS)
      ) u_port (
         .clock      (clock),
         .reset      (reset),
         .req_valid  (p_req_valid[i]),
         .req_ready  (p_req_ready[i]),
         .vpn2       (p_vpn2[i]),
         .asid       (p_asid[i]),
         .kill       (p_kill[i]),
         .group      (group_rd),
         .sp         (sp),
         .commit     (commit),
         .resp_valid (p_resp_valid[i]),
         .resp_hit   (p_resp_hit[i]),
         .resp_index (p_resp_index[i]),
         .resp_entry (p_resp_entry[i])
      );
   end

endmodule

// File: tb/tb_mips32r2_scan_tlb.sv
// Directed bench for the rotating-scan TLB: writes, reads, probe hits,
// misses, page-size masking, kill and write/probe coherence.
module tb_mips32r2_scan_tlb;
   import mips32r2_scan_tlb_pkg::*;

   logic                  clock;
   logic                  reset;
   logic                  r_valid;
   logic [5:0]            r_index;
   logic                  r_ready;
   tlb_entry_t            r_resp;
   logic                  w_valid;
   logic [5:0]            w_index;
   tlb_entry_t            w_data;
   logic                  w_ready;
   logic [1:0]            p_req_valid;
   logic [1:0]            p_req_ready;
   logic [1:0][18:0]      p_vpn2;
   logic [1:0][7:0]       p_asid;
   logic [1:0]            p_kill;
   logic [1:0]            p_resp_valid;
   logic [1:0]            p_resp_hit;
   logic [1:0][5:0]       p_resp_index;
   tlb_entry_t [1:0]      p_resp_entry;

   int n_cmp = 0;
   int n_err = 0;
   int sp_m;

   mips32r2_scan_tlb #(
      .ENTRIES         (64),
      .GROUP_SIZE      (4),
      .NUM_PROBE_PORTS (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .r_valid      (r_valid),
      .r_index      (r_index),
      .r_ready      (r_ready),
      .r_resp       (r_resp),
      .w_valid      (w_valid),
      .w_index      (w_index),
      .w_data       (w_data),
      .w_ready      (w_ready),
      .p_req_valid  (p_req_valid),
      .p_req_ready  (p_req_ready),
      .p_vpn2       (p_vpn2),
      .p_asid       (p_asid),
      .p_kill       (p_kill),
      .p_resp_valid (p_resp_valid),
      .p_resp_hit   (p_resp_hit),
      .p_resp_index (p_resp_index),
      .p_resp_entry (p_resp_entry)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scan pointer reference: advances every cycle except a write commit.
   always @(posedge clock) begin
      if (reset) sp_m <= 0;
      else if (w_valid && (int'(w_index[5:2]) == sp_m)) sp_m <= sp_m;
      else sp_m <= (sp_m + 1) % 16;
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; a write that committed this cycle is withdrawn.
   task automatic tick();
      logic c;
      c = w_valid && w_ready;
      @(posedge clock);
      @(negedge clock);
      if (c) w_valid = 1'b0;
      #1;
   endtask

   function automatic tlb_entry_t mk(logic [18:0] v, logic [7:0] a,
                                     logic g, page_size_e ps);
      tlb_entry_t e;
      e      = '0;
      e.vpn2 = v;
      e.asid = a;
      e.g    = g;
      e.ps   = ps;
      e.pfn0 = {1'b0, v};
      e.v0   = 1'b1;
      return e;
   endfunction

   function automatic int hit_lat(int grp);
      return ((grp - sp_m - 1) & 15) + 2;
   endfunction

   task automatic write_entry(int idx, tlb_entry_t e);
      logic done;
      done    = 1'b0;
      w_valid = 1'b1;
      w_index = idx[5:0];
      w_data  = e;
      for (int n = 0; n < 20 && !done; n++) begin
         #1;
         if (w_ready) done = 1'b1;
         else tick();
      end
      chk("wr_commit", {63'd0, done}, 64'd1);
      tick();
      w_valid = 1'b0;
   endtask

   task automatic probe(int port, logic [18:0] v, logic [7:0] a,
                        logic eh, int ei, int elat, string tag);
      int lat;
      p_vpn2[port]      = v;
      p_asid[port]      = a;
      p_req_valid[port] = 1'b1;
      #1;
      chk({tag, "_ready"}, {63'd0, p_req_ready[port]}, 64'd1);
      tick();
      p_req_valid[port] = 1'b0;
      lat = 1;
      while (!p_resp_valid[port] && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_hit"}, {63'd0, p_resp_hit[port]}, {63'd0, eh});
      chk({tag, "_idx"}, {58'd0, p_resp_index[port]}, 64'(ei));
      if (eh)
         chk({tag, "_vpn2"}, {45'd0, p_resp_entry[port].vpn2}, {45'd0, v & vpn2_mask(p_resp_entry[port].ps)} | {45'd0, p_resp_entry[port].vpn2 & ~vpn2_mask(p_resp_entry[port].ps)});
      else
         chk({tag, "_zero"}, {63'd0, p_resp_entry[port] == '0}, 64'd1);
      tick();
      chk({tag, "_pulse1"}, {63'd0, p_resp_valid[port]}, 64'd0);
      tick();
   endtask

   initial begin
      int s;
      int g;
      int idx;
      logic seen;
      reset       = 1'b1;
      r_valid     = 1'b0;
      r_index     = '0;
      w_valid     = 1'b0;
      w_index     = '0;
      w_data      = '0;
      p_req_valid = '0;
      p_vpn2      = '0;
      p_asid      = '0;
      p_kill      = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk("rst_req_ready", {62'd0, p_req_ready}, 64'h3);
      chk("rst_resp_valid", {62'd0, p_resp_valid}, 64'h0);
      chk("rst_resp_hit", {62'd0, p_resp_hit}, 64'h0);
      chk("rst_resp_index", {52'd0, p_resp_index}, 64'h0);
      chk("rst_resp_entry", {63'd0, p_resp_entry == '0}, 64'd1);
      chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
      chk("rst_w_ready", {63'd0, w_ready}, 64'd0);

      // Entry 13 lives in group 3; sp starts at 0, commit 3 cycles later.
      reset   = 1'b0;
      w_valid = 1'b1;
      w_index = 6'd13;
      w_data  = mk(19'h12345, 8'h00, 1'b1, PS4K);
      #1;
      chk("wr13_sp0", {63'd0, w_ready}, 64'd0);
      tick();
      chk("wr13_sp1", {63'd0, w_ready}, 64'd0);
      tick();
      chk("wr13_sp2", {63'd0, w_ready}, 64'd0);
      tick();
      chk("wr13_sp3", {63'd0, w_ready}, 64'd1);
      r_valid = 1'b1;
      r_index = 6'd13;
      #1;
      chk("rd_blocked_by_wr", {63'd0, r_ready}, 64'd0);
      chk("rd_blocked_zero", {63'd0, r_resp == '0}, 64'd1);
      tick();
      chk("rd13_ready_held_sp", {63'd0, r_ready}, 64'd1);
      chk("rd13_vpn2", {45'd0, r_resp.vpn2}, 64'h12345);
      chk("rd13_g", {63'd0, r_resp.g}, 64'd1);
      tick();
      chk("rd13_gone", {63'd0, r_ready}, 64'd0);
      r_valid = 1'b0;

      for (int i = 0; i < 64; i++) begin
         if (i == 40)
            write_entry(i, mk(19'h00a30, 8'h05, 1'b0, PS64K));
         else if (i != 13)
            write_entry(i, mk(19'h40000 | 19'(i), 8'hff, 1'b0, PS4K));
      end

      probe(0, 19'h12345, 8'h07, 1'b1, 13, hit_lat(3), "p0_hit13");
      probe(0, 19'h7ffff, 8'h07, 1'b0, 0, 17, "p0_miss");
      probe(1, 19'h00a3f, 8'h05, 1'b1, 40, hit_lat(10), "p1_hit40");
      probe(1, 19'h00a3f, 8'h06, 1'b0, 0, 17, "p1_asid_miss");

      // Kill three cycles into a sweep.
      p_vpn2[0]      = 19'h7ffff;
      p_asid[0]      = 8'h07;
      p_req_valid[0] = 1'b1;
      #1;
      chk("kill_accept", {63'd0, p_req_ready[0]}, 64'd1);
      tick();
      p_req_valid[0] = 1'b0;
      tick();
      tick();
      p_kill[0] = 1'b1;
      #1;
      chk("kill_no_pulse", {63'd0, p_resp_valid[0]}, 64'd0);
      tick();
      p_kill[0] = 1'b0;
      #1;
      chk("kill_idle", {63'd0, p_req_ready[0]}, 64'd1);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         seen |= p_resp_valid[0];
         tick();
      end
      chk("kill_silent", {63'd0, seen}, 64'd0);
      probe(0, 19'h12345, 8'h07, 1'b1, 13, hit_lat(3), "p0_after_kill");

      // Both ports chase an entry rewritten in group sp+2.
      s   = sp_m;
      g   = (s + 2) % 16;
      idx = g * 4 + 2;
      p_vpn2         = {19'h55555, 19'h55555};
      p_asid         = {8'h01, 8'h01};
      p_req_valid    = 2'b11;
      w_valid        = 1'b1;
      w_index        = idx[5:0];
      w_data         = mk(19'h55555, 8'h01, 1'b0, PS4K);
      #1;
      chk("coh_accept", {62'd0, p_req_ready}, 64'h3);
      chk("coh_no_commit_t0", {63'd0, w_ready}, 64'd0);
      tick();
      p_req_valid = 2'b00;
      chk("coh_no_commit_t1", {63'd0, w_ready}, 64'd0);
      tick();
      chk("coh_commit_t2", {63'd0, w_ready}, 64'd1);
      chk("coh_no_resp_t2", {62'd0, p_resp_valid}, 64'h0);
      tick();
      r_valid = 1'b1;
      r_index = idx[5:0];
      #1;
      chk("coh_sp_held", {63'd0, r_ready}, 64'd1);
      chk("coh_rd_new", {45'd0, r_resp.vpn2}, 64'h55555);
      chk("coh_no_resp_t3", {62'd0, p_resp_valid}, 64'h0);
      tick();
      r_valid = 1'b0;
      chk("coh_resp_valid", {62'd0, p_resp_valid}, 64'h3);
      chk("coh_resp_hit", {62'd0, p_resp_hit}, 64'h3);
      chk("coh_idx0", {58'd0, p_resp_index[0]}, 64'(idx));
      chk("coh_idx1", {58'd0, p_resp_index[1]}, 64'(idx));
      chk("coh_vpn2_0", {45'd0, p_resp_entry[0].vpn2}, 64'h55555);
      chk("coh_vpn2_1", {45'd0, p_resp_entry[1].vpn2}, 64'h55555);
      tick();
      chk("coh_pulse1", {62'd0, p_resp_valid}, 64'h0);
      tick();

      // A commit during a missing sweep stretches it by one cycle.
      s   = sp_m;
      idx = ((s + 2) % 16) * 4 + 3;
      w_valid = 1'b1;
      w_index = idx[5:0];
      w_data  = mk(19'h66666, 8'hff, 1'b0, PS4K);
      probe(0, 19'h7ffff, 8'h07, 1'b0, 0, 18, "p0_miss_wr");
      chk("miss_wr_done", {63'd0, w_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
